// File: rtl/out_arb_pkg.sv
// rtl/out_arb_pkg.sv - shared FSM states, no-master constant and one-hot decode for the output arbiter
package out_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int MAX_INPUTS = 16;

  function automatic int no_master(input int num_inputs);
    return num_inputs;
  endfunction

  // Out-of-range selects (including the no-master value) decode to all-zero.
  function automatic logic [MAX_INPUTS-1:0] onehot_decode(input int sel, input int num_inputs);
    logic [MAX_INPUTS-1:0] dec;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      dec[i] = (i == sel) && (i < num_inputs);
    end
    return dec;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational search for the first asserted request at or after a start index
module rr_priority_picker
  import out_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int SEL_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_W-1:0]      start,
  output logic [SEL_W-1:0]      idx,
  output logic                  found
);

  always_comb begin
    int cand;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = int'(start) + i;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      // Nested scan keeps every request index a constant bit select.
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (!found && (j == cand) && req[j]) begin
          found = 1'b1;
          idx   = SEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - output arbiter with transaction hold; OUTARB_ROUND_ROBIN_EN selects rotating priority
module rr_output_arbiter
  import out_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int SEL_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [NUM_INPUTS-1:0] i_In_Req,
  input  logic [NUM_INPUTS-1:0] i_In_NewTransaction,
  output logic [SEL_W-1:0]      o_MuxSel,
  output logic [NUM_INPUTS-1:0] o_Grant,
  output logic                  o_Busy
);

  localparam logic [SEL_W-1:0] NO_SEL = SEL_W'(no_master(NUM_INPUTS));

  arb_state_e            state, next_state;
  logic                  keep;
  logic [SEL_W-1:0]      pick_start, pick_idx, next_sel;
  logic                  pick_found;
  logic [NUM_INPUTS-1:0] next_grant;
  logic [MAX_INPUTS-1:0] dec;

`ifdef OUTARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] last_winner;

  assign pick_start = (last_winner == SEL_W'(NUM_INPUTS - 1)) ? '0 : last_winner + 1'b1;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      last_winner <= SEL_W'(NUM_INPUTS - 1);
    end else if (!keep && pick_found) begin
      last_winner <= pick_idx;
    end
  end
`else
  assign pick_start = '0;
`endif

  rr_priority_picker #(
    .NUM_INPUTS(NUM_INPUTS),
    .SEL_W     (SEL_W)
  ) u_picker (
    .req  (i_In_Req),
    .start(pick_start),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // o_Grant masks the owner's bits, so no variable index into the request vectors is needed.
  assign keep = (state == ST_OWNED) && (|(i_In_Req & ~i_In_NewTransaction & o_Grant));

  always_comb begin
    next_state = ST_IDLE;
    next_sel   = NO_SEL;
    if (keep) begin
      next_state = ST_OWNED;
      next_sel   = o_MuxSel;
    end else if (pick_found) begin
      next_state = ST_OWNED;
      next_sel   = pick_idx;
    end
    dec        = onehot_decode(int'(next_sel), NUM_INPUTS);
    next_grant = dec[NUM_INPUTS-1:0];
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= ST_IDLE;
      o_MuxSel <= NO_SEL;
      o_Grant  <= '0;
      o_Busy   <= 1'b0;
    end else begin
      state    <= next_state;
      o_MuxSel <= next_sel;
      o_Grant  <= next_grant;
      o_Busy   <= (next_state == ST_OWNED);
    end
  end

endmodule

// File: doc/rr_output_arbiter.md
RR_OUTPUT_ARBITER -- requirements
Module: rr_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5, giving the number of requesting masters (legal 2..16).
REQ-002 SHALL have parameter SEL_W, default $clog2(NUM_INPUTS+1), giving the width of the select output.
REQ-003 SHALL have port i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_In_Req  input  NUM_INPUTS  per-master request.
REQ-006 SHALL have port i_In_NewTransaction  input  NUM_INPUTS  per-master flag: the current request starts a new transaction.
REQ-007 SHALL have port o_MuxSel  output  SEL_W  registered index of the granted master; value NUM_INPUTS means no master.
REQ-008 SHALL have port o_Grant  output  NUM_INPUTS  registered one-hot grant, all-zero when idle.
REQ-009 SHALL have port o_Busy  output  1  registered; high while any master holds the grant.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and OWNED (one master g holds the grant).
REQ-011 SHALL register every grant decision: a decision made from cycle-N inputs appears on the outputs in cycle N+1 (one-cycle latency).
REQ-012 In OWNED, SHALL keep g when i_In_Req[g]=1 and i_In_NewTransaction[g]=0, regardless of other requests.
REQ-013 In OWNED, when i_In_Req[g]=0 or i_In_NewTransaction[g]=1, SHALL re-arbitrate among all asserted requests, including g.
REQ-014 In IDLE, SHALL arbitrate every cycle among asserted requests; with no requests it SHALL stay IDLE.
REQ-015 Arbitration SHALL select exactly one requester using the priority order defined in Configuration.
REQ-016 When arbitration finds no requester, SHALL go to IDLE with o_MuxSel=NUM_INPUTS, o_Grant=0, o_Busy=0.
REQ-017 o_Grant SHALL always equal the one-hot decode of o_MuxSel, all-zero for the value NUM_INPUTS.
REQ-018 o_Busy SHALL equal (o_MuxSel != NUM_INPUTS).
REQ-019 SHALL keep a last-winner pointer, updated only on a cycle where a new arbitration grants a master.
REQ-020 SHALL ignore i_In_NewTransaction bits of non-requesting masters.
REQ-021 A grant change SHALL never produce an intermediate idle cycle when another requester is pending.

Reset
REQ-022 Asserting i_Rst, including mid-transaction, SHALL immediately force IDLE, o_MuxSel=NUM_INPUTS, o_Grant=0 and o_Busy=0.
REQ-023 Asserting i_Rst SHALL set the last-winner pointer to NUM_INPUTS-1, so that master 0 has top priority after reset.
REQ-024 On the first clock edge after i_Rst deasserts, SHALL arbitrate normally.

Configuration
REQ-025 Macro OUTARB_ROUND_ROBIN_EN SHALL select the arbitration policy at compile time.
REQ-026 With OUTARB_ROUND_ROBIN_EN defined, priority SHALL rotate: search starts at last-winner+1 modulo NUM_INPUTS, so the previous winner ranks lowest.
REQ-027 Without OUTARB_ROUND_ROBIN_EN, priority SHALL be fixed with the lowest index highest; the pointer is then unused and may be removed by synthesis.

Structure
REQ-028 Shared package out_arb_pkg SHALL hold: the FSM state enumeration, the no-master constant function (returns NUM_INPUTS), and a one-hot decode function.
REQ-029 Priority search SHALL live in sub-module rr_priority_picker.
REQ-030 rr_priority_picker SHALL be purely combinational: request vector and start index in; index and found flag out.
REQ-031 The FSM, pointer and output registers SHALL reside in rr_output_arbiter.

Verification
REQ-032 Reset behaviour: assert i_Rst with i_In_Req=5'b11111 -> o_MuxSel=5, o_Grant=0, o_Busy=0 while reset is held.
REQ-033 Fixed priority (macro off): i_In_Req=5'b10110 in cycle 0 -> o_MuxSel=1 and o_Grant=5'b00010 in cycle 1.
REQ-034 Continuing transaction: master 3 granted, then i_In_Req=5'b01001 with NewTransaction[3]=0 for 4 cycles -> o_MuxSel stays 3.
REQ-035 Round robin (macro on): all five requesting, NewTransaction=1 every cycle -> o_MuxSel sequence 0,1,2,3,4,0.
REQ-036 Release: the granted master drops its request with no other requester -> next cycle o_MuxSel=NUM_INPUTS, o_Busy=0.
REQ-037 Handover: the granted master drops its request while master 2 requests -> next cycle o_MuxSel=2 with no idle gap.
REQ-038 Reset mid-operation: assert i_Rst while o_MuxSel=2 -> outputs go idle immediately, then master 0 wins first after release.
REQ-039 Parameter sweep: repeat the fixed-priority check at NUM_INPUTS=2 -> i_In_Req=2'b10 gives o_MuxSel=1 with SEL_W=2.
